// File: rtl/money_pkg.sv
// Shared types, tile geometry and pallet screen origins for the money pallet renderer.
package money_pkg;

    typedef logic [1:0] level_t;

    localparam level_t LEVEL_EMPTY = 2'd0;
    localparam level_t LEVEL_HALF  = 2'd1;
    localparam level_t LEVEL_FULL  = 2'd2;

    localparam int unsigned TILE_W      = 18;
    localparam int unsigned TILE_H      = 18;
    localparam int unsigned MAX_PALLETS = 8;

    localparam logic [5:0] TRANSPARENT = 6'h00;

    // Pallets 0 and 1 deliberately overlap so draw priority is visible on screen.
    localparam logic [9:0] PALLET_X [MAX_PALLETS] = '{
        10'd40, 10'd50, 10'd200, 10'd260, 10'd40, 10'd100, 10'd160, 10'd220
    };
    localparam logic [9:0] PALLET_Y [MAX_PALLETS] = '{
        10'd100, 10'd105, 10'd100, 10'd100, 10'd300, 10'd300, 10'd300, 10'd300
    };

    // Half-open span test done one bit wider so origin+span cannot wrap.
    function automatic logic in_span(input logic [9:0]  pos,
                                     input logic [9:0]  origin,
                                     input logic [10:0] span);
        return ({1'b0, pos} >= {1'b0, origin}) &&
               ({1'b0, pos} <  ({1'b0, origin} + span));
    endfunction

endpackage

// File: rtl/money_pallet_slot.sv
// One pallet slot: fill level, frame-driven refill counter and grab-accept pulse.
module money_pallet_slot
    import money_pkg::*;
#(
    parameter int unsigned REFILL_FRAMES = 180
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   frame_start,
    input  logic   grab,
    output logic   grab_ok,
    output level_t level
);

    localparam int unsigned CNT_W = (REFILL_FRAMES > 1) ? $clog2(REFILL_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFILL_FRAMES - 1);

    level_t           level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grab_ok_q, grab_ok_d;
    logic             grab_acc;
    logic             refill;

    always_comb begin
        grab_acc  = grab && (level_q != LEVEL_EMPTY);
        refill    = frame_start && (level_q != LEVEL_FULL) && (cnt_q == CNT_LAST);
        level_d   = level_q;
        cnt_d     = cnt_q;
        grab_ok_d = grab_acc;

        // A grab and a refill landing together cancel out on the level.
        if (grab_acc && !refill) begin
            level_d = level_q - 2'd1;
        end else if (refill && !grab_acc) begin
            level_d = level_q + 2'd1;
        end

        if (grab_acc || (level_q == LEVEL_FULL)) begin
            cnt_d = '0;
        end else if (frame_start) begin
            cnt_d = refill ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q   <= LEVEL_FULL;
            cnt_q     <= '0;
            grab_ok_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            grab_ok_q <= grab_ok_d;
        end
    end

    assign level   = level_q;
    assign grab_ok = grab_ok_q;

endmodule

// File: rtl/money_pallet_renderer.sv
// Money pallet state plus 2-stage hit-detect / tile-ROM render pipeline.
// Optional MONEY_SHIMMER_EN: full pallets alternate to the half tile every SHIMMER_FRAMES frames.
module money_pallet_renderer
    import money_pkg::*;
#(
    parameter int unsigned NUM_PALLETS    = 4,
    parameter int unsigned REFILL_FRAMES  = 180,
    parameter int unsigned SHIMMER_FRAMES = 16
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     FrameStart,
    input  logic [9:0]               DrawX,
    input  logic [9:0]               DrawY,
    input  logic [NUM_PALLETS-1:0]   Grab,
    output logic [NUM_PALLETS-1:0]   GrabOk,
    output logic [2*NUM_PALLETS-1:0] Level,
    output logic [1:0]               Tile,
    output logic [4:0]               PixelX,
    output logic [4:0]               PixelY,
    input  logic [5:0]               RomData,
    output logic [5:0]               PixelColor,
    output logic                     PixelValid
);

    if ((NUM_PALLETS < 1) || (NUM_PALLETS > MAX_PALLETS)) begin : g_bad_num_pallets
        $error("NUM_PALLETS must be in 1..8");
    end
    if ((REFILL_FRAMES < 1) || (SHIMMER_FRAMES < 1)) begin : g_bad_frames
        $error("REFILL_FRAMES and SHIMMER_FRAMES must be at least 1");
    end

    level_t slot_level [NUM_PALLETS];

    for (genvar i = 0; i < NUM_PALLETS; i++) begin : g_slot
        money_pallet_slot #(
            .REFILL_FRAMES(REFILL_FRAMES)
        ) u_slot (
            .clk        (Clk),
            .rst_n      (Reset_n),
            .frame_start(FrameStart),
            .grab       (Grab[i]),
            .grab_ok    (GrabOk[i]),
            .level      (slot_level[i])
        );
        assign Level[2*i +: 2] = slot_level[i];
    end

    logic shimmer_phase;

`ifdef MONEY_SHIMMER_EN
    localparam int unsigned SH_W = (SHIMMER_FRAMES > 1) ? $clog2(SHIMMER_FRAMES) : 1;
    localparam logic [SH_W-1:0] SH_LAST = SH_W'(SHIMMER_FRAMES - 1);

    logic [SH_W-1:0] shim_cnt_q, shim_cnt_d;
    logic            shim_phase_q, shim_phase_d;

    always_comb begin
        shim_cnt_d   = shim_cnt_q;
        shim_phase_d = shim_phase_q;
        if (FrameStart) begin
            if (shim_cnt_q == SH_LAST) begin
                shim_cnt_d   = '0;
                shim_phase_d = ~shim_phase_q;
            end else begin
                shim_cnt_d = shim_cnt_q + SH_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shim_cnt_q   <= '0;
            shim_phase_q <= 1'b0;
        end else begin
            shim_cnt_q   <= shim_cnt_d;
            shim_phase_q <= shim_phase_d;
        end
    end

    assign shimmer_phase = shim_phase_q;
`else
    assign shimmer_phase = 1'b0;
`endif

    // S0: lowest-index pallet covering the draw point wins.
    logic       hit;
    level_t     win_level;
    logic [9:0] win_x;
    logic [9:0] win_y;
    level_t     disp_tile;

    always_comb begin
        hit       = 1'b0;
        win_level = LEVEL_EMPTY;
        win_x     = '0;
        win_y     = '0;
        for (int unsigned i = 0; i < NUM_PALLETS; i++) begin
            if (!hit &&
                in_span(DrawX, PALLET_X[i], 11'(TILE_W)) &&
                in_span(DrawY, PALLET_Y[i], 11'(TILE_H))) begin
                hit       = 1'b1;
                win_level = slot_level[i];
                win_x     = PALLET_X[i];
                win_y     = PALLET_Y[i];
            end
        end
        disp_tile = (shimmer_phase && (win_level == LEVEL_FULL)) ? LEVEL_HALF : win_level;
    end

    logic [1:0] tile_q, tile_d;
    logic [4:0] pixel_x_q, pixel_x_d;
    logic [4:0] pixel_y_q, pixel_y_d;
    logic       hit_d1_q, hit_d1_d;
    logic [5:0] pixel_color_q, pixel_color_d;
    logic       pixel_valid_q, pixel_valid_d;

    always_comb begin
        tile_d        = '0;
        pixel_x_d     = '0;
        pixel_y_d     = '0;
        hit_d1_d      = hit;
        if (hit) begin
            tile_d    = disp_tile;
            pixel_x_d = 5'(DrawX - win_x);
            pixel_y_d = 5'(DrawY - win_y);
        end
        pixel_color_d = RomData;
        pixel_valid_d = hit_d1_q && (RomData != TRANSPARENT);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tile_q        <= '0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            hit_d1_q      <= 1'b0;
            pixel_color_q <= '0;
            pixel_valid_q <= 1'b0;
        end else begin
            tile_q        <= tile_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            hit_d1_q      <= hit_d1_d;
            pixel_color_q <= pixel_color_d;
            pixel_valid_q <= pixel_valid_d;
        end
    end

    assign Tile       = tile_q;
    assign PixelX     = pixel_x_q;
    assign PixelY     = pixel_y_q;
    assign PixelColor = pixel_color_q;
    assign PixelValid = pixel_valid_q;

endmodule
